// File: rtl/counter_snapshot_fifo.sv
// Captures {counter value, elapsed count since previous capture} into a small FIFO
// drained over valid/ready; also counts counter wrap-arounds and flags dropped captures.
module counter_snapshot_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         count_in,
  input  logic                     sample,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_value,
  output logic [WIDTH-1:0]         out_delta,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     overflow,
  output logic [7:0]               wrap_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  function automatic logic [7:0] sat_inc(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  logic [WIDTH-1:0] val_mem   [DEPTH];
  logic [WIDTH-1:0] delta_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] last_cap_q, last_cap_d;
  logic [WIDTH-1:0] prev_count_q, prev_count_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       wrap_count_q, wrap_count_d;

  logic             valid_w, full_w, pop, push, drop;
  logic [WIDTH-1:0] new_delta;

  // Status flags come from registered occupancy only, never from this cycle's handshake.
  assign valid_w   = (level_q != '0);
  assign full_w    = (level_q == LVL_W'(DEPTH));
  assign pop       = valid_w && out_ready;
  assign push      = sample && (!full_w || pop);
  assign drop      = sample && full_w && !pop;
  assign new_delta = count_in - last_cap_q;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    last_cap_d   = last_cap_q;
    overflow_d   = overflow_q;
    prev_count_d = count_in;
    wrap_count_d = wrap_count_q;

    if (push) begin
      wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      last_cap_d = count_in;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LVL_W'(1);
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
    // A smaller value than last cycle means the upstream counter rolled over.
    if (count_in < prev_count_q) begin
      wrap_count_d = sat_inc(wrap_count_q);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      last_cap_q   <= '0;
      prev_count_q <= '0;
      overflow_q   <= 1'b0;
      wrap_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      last_cap_q   <= last_cap_d;
      prev_count_q <= prev_count_d;
      overflow_q   <= overflow_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  // Storage holds data only; occupancy alone decides which slots are meaningful.
  always_ff @(posedge clock) begin
    if (push) begin
      val_mem[wr_ptr_q]   <= count_in;
      delta_mem[wr_ptr_q] <= new_delta;
    end
  end

  assign out_valid  = valid_w;
  assign out_value  = val_mem[rd_ptr_q];
  assign out_delta  = delta_mem[rd_ptr_q];
  assign level      = level_q;
  assign full       = full_w;
  assign overflow   = overflow_q;
  assign wrap_count = wrap_count_q;

endmodule
